apb_mailbox_slave: RTL and testbench

// - APB completer at the downstream end of the AHB-to-APB bridge; it consumes the bridge's APB transfers.
// - APB writes to DATA push into a TX FIFO, drained by a local valid/ready stream.
// - A local stream fills an RX FIFO; APB reads of DATA pop it.
// - Wait states (Pready low) stall the bridge while TX is full or RX is empty, up to a bounded timeout.

---
 rtl/apb_mailbox_pkg.sv | 36 +++
 rtl/mb_sync_fifo.sv | 58 +++++
 rtl/apb_mailbox_slave.sv | 129 ++++++++++++
 tb/tb_apb_mailbox_slave.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mailbox_pkg.sv
// Shared register map, STATUS layout and address decode for the APB mailbox.
package apb_mailbox_pkg;

  localparam logic [31:0] OFF_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CTRL   = 32'h0000_0008;

  localparam int ST_ERR_BIT    = 31;
  localparam int ST_RXCNT_LSB  = 16;
  localparam int ST_TXCNT_LSB  = 8;
  localparam int ST_REMPTY_BIT = 1;
  localparam int ST_WFULL_BIT  = 0;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_DATA,
    REG_STATUS,
    REG_CTRL
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr == base + OFF_DATA) begin
      sel = REG_DATA;
    end else if (addr == base + OFF_STATUS) begin
      sel = REG_STATUS;
    end else if (addr == base + OFF_CTRL) begin
      sel = REG_CTRL;
    end
    return sel;
  endfunction

endpackage

// File: rtl/mb_sync_fifo.sv
// Single-clock FIFO with registered count; full/empty never bypass a same-cycle pop/push.
module mb_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && (count_q != DEPTH_C);
    do_pop   = pop && (count_q != '0);
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/apb_mailbox_slave.sv
// APB completer bridging a 3-register window onto a TX stream FIFO and an RX stream FIFO,
// stalling DATA accesses on full/empty for at most TIMEOUT cycles.
module apb_mailbox_slave
  import apb_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter int          TIMEOUT   = 16
) (
  input  logic        Pclk,
  input  logic        Preset,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pdata,
  output logic        Pready,
  output logic [31:0] rdata_temp,
  output logic        wfull,
  output logic        rempty,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam int WW   = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  reg_sel_e         sel;
  logic             access, blocked, gave_up, done;
  logic [WW-1:0]    wait_q, wait_d;
  logic             err_q, err_d;
  logic             tx_push, rx_pop;
  logic             tx_full, tx_empty, rx_full, rx_empty;
  logic [TXCW-1:0]  tx_count;
  logic [RXCW-1:0]  rx_count;
  logic [31:0]      rx_head;
  logic [31:0]      status_word;

  // Access qualification, stall and timeout decision.
  always_comb begin
    sel     = decode_addr(Paddr, BASE_ADDR);
    access  = Psel && Penable && !Preset;
    blocked = access && (sel == REG_DATA) && (Pwrite ? tx_full : rx_empty);
    gave_up = blocked && (wait_q == TIMEOUT_C);
    done    = access && (!blocked || gave_up);
    tx_push = done && (sel == REG_DATA) && Pwrite && !gave_up;
    rx_pop  = done && (sel == REG_DATA) && !Pwrite && !gave_up;

    wait_d = wait_q;
    if (!Psel || done) begin
      wait_d = '0;
    end else if (blocked) begin
      wait_d = wait_q + WW'(1);
    end

    err_d = err_q;
    if (gave_up) begin
      err_d = 1'b1;
    end else if (done && (sel == REG_CTRL) && Pwrite && Pdata[0]) begin
      err_d = 1'b0;
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[ST_ERR_BIT]              = err_q;
    status_word[ST_RXCNT_LSB +: 8]       = 8'(rx_count);
    status_word[ST_TXCNT_LSB +: 8]       = 8'(tx_count);
    status_word[ST_REMPTY_BIT]           = rx_empty;
    status_word[ST_WFULL_BIT]            = tx_full;

    rdata_temp = '0;
    if (done && !Pwrite) begin
      case (sel)
        REG_DATA:   rdata_temp = gave_up ? TIMEOUT_DATA : rx_head;
        REG_STATUS: rdata_temp = status_word;
        default:    rdata_temp = '0;
      endcase
    end
  end

  always_ff @(posedge Pclk or posedge Preset) begin
    if (Preset) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  mb_sync_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (Pclk),
    .rst   (Preset),
    .push  (tx_push),
    .pop   (tx_ready),
    .din   (Pdata),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  mb_sync_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (Pclk),
    .rst   (Preset),
    .push  (rx_valid),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  assign Pready   = done;
  assign wfull    = tx_full;
  assign rempty   = rx_empty;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

endmodule

// File: tb/tb_apb_mailbox_slave.sv
// Directed bench for apb_mailbox_slave with a queue-based reference model checked every cycle.
`timescale 1ns/1ps
module tb_apb_mailbox_slave;

  localparam int          TXD  = 8;
  localparam int          RXD  = 8;
  localparam int          TMO  = 16;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        Pclk = 1'b0;
  logic        Preset, Psel, Penable, Pwrite;
  logic [31:0] Paddr, Pdata, rdata_temp, tx_data, rx_data;
  logic        Pready, wfull, rempty, tx_valid, tx_ready, rx_valid, rx_ready;

  int checks = 0;
  int errors = 0;

  apb_mailbox_slave #(
    .BASE_ADDR (BASE),
    .TX_DEPTH  (TXD),
    .RX_DEPTH  (RXD),
    .TIMEOUT   (TMO)
  ) dut (
    .Pclk       (Pclk),
    .Preset     (Preset),
    .Psel       (Psel),
    .Penable    (Penable),
    .Pwrite     (Pwrite),
    .Paddr      (Paddr),
    .Pdata      (Pdata),
    .Pready     (Pready),
    .rdata_temp (rdata_temp),
    .wfull      (wfull),
    .rempty     (rempty),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready)
  );

  always #5 Pclk = ~Pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: mailbox contents as queues, sticky error, stall cycles spent on the current access.
  logic [31:0] m_tx[$];
  logic [31:0] m_rx[$];
  bit          m_err  = 1'b0;
  int          m_wait = 0;

  function automatic void m_eval(output bit acc, output bit blk, output bit gave, output bit rdy);
    acc  = Psel && Penable;
    blk  = acc && (Paddr == BASE) && (Pwrite ? (m_tx.size() == TXD) : (m_rx.size() == 0));
    gave = blk && (m_wait == TMO);
    rdy  = acc && (!blk || gave);
  endfunction

  always @(negedge Pclk) begin
    bit          acc, blk, gave, rdy;
    logic [31:0] er;
    if (Preset) begin
      check("rst_pready", {31'd0, Pready}, 32'd0);
      check("rst_rdata", rdata_temp, 32'd0);
      check("rst_wfull", {31'd0, wfull}, 32'd0);
      check("rst_rempty", {31'd0, rempty}, 32'd1);
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    end else begin
      m_eval(acc, blk, gave, rdy);
      er = 32'd0;
      if (rdy && !Pwrite) begin
        if (Paddr == BASE) begin
          er = gave ? 32'hDEAD_BEEF : m_rx[0];
        end else if (Paddr == BASE + 32'd4) begin
          er = {m_err, 7'd0, 8'(m_rx.size()), 8'(m_tx.size()), 6'd0,
                (m_rx.size() == 0), (m_tx.size() == TXD)};
        end
      end
      check("pready", {31'd0, Pready}, {31'd0, rdy});
      check("rdata", rdata_temp, er);
      check("wfull", {31'd0, wfull}, {31'd0, m_tx.size() == TXD});
      check("rempty", {31'd0, rempty}, {31'd0, m_rx.size() == 0});
      check("tx_valid", {31'd0, tx_valid}, {31'd0, m_tx.size() != 0});
      check("rx_ready", {31'd0, rx_ready}, {31'd0, m_rx.size() < RXD});
      if (m_tx.size() != 0) check("tx_data", tx_data, m_tx[0]);
    end
  end

  always @(posedge Pclk) begin
    bit acc, blk, gave, rdy;
    int ntx, nrx;
    if (Preset) begin
      m_tx.delete();
      m_rx.delete();
      m_err  = 1'b0;
      m_wait = 0;
    end else begin
      m_eval(acc, blk, gave, rdy);
      ntx = m_tx.size();
      nrx = m_rx.size();
      if (tx_ready && ntx > 0) void'(m_tx.pop_front());
      if (rdy) begin
        if (Paddr == BASE && !gave) begin
          if (Pwrite) m_tx.push_back(Pdata);
          else void'(m_rx.pop_front());
        end
        if (gave) m_err = 1'b1;
        if (Paddr == BASE + 32'd8 && Pwrite && Pdata[0]) m_err = 1'b0;
        m_wait = 0;
      end else if (blk) begin
        m_wait++;
      end
      if (!Psel) m_wait = 0;
      if (rx_valid && nrx < RXD) m_rx.push_back(rx_data);
    end
  end

  // One APB transfer; optionally strobes tx_ready or rx_valid for one cycle on access cycle strobe_cyc.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int strobe_cyc, input bit s_tx, input bit s_rx, input logic [31:0] s_data,
                     output logic [31:0] rd, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    rd    = 32'd0;
    Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pdata = wdata;
    @(posedge Pclk); #1;
    Penable = 1'b1;
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      if (cyc == strobe_cyc) begin
        tx_ready = s_tx; rx_valid = s_rx; rx_data = s_data;
      end
      @(negedge Pclk);
      if (Pready) begin
        rd   = rdata_temp;
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge Pclk); #1;
      if (cyc == strobe_cyc) begin
        tx_ready = 1'b0; rx_valid = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL apb_wait_bound: Pready still 0 after %0d cycles, expected completion", waits);
    end
    Psel = 1'b0; Penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    int          w;
    Preset = 1'b1; Psel = 1'b0; Penable = 1'b0; Pwrite = 1'b0;
    Paddr = 32'd0; Pdata = 32'd0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 32'd0;
    repeat (3) @(posedge Pclk);
    #1 Preset = 1'b0;

    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("first_status", rd, 32'h0000_0002);
    check("first_status_waits", w, 0);

    for (int i = 1; i <= 8; i++) begin
      apb(1'b1, BASE, 32'(i), 0, 1'b0, 1'b0, 32'd0, rd, w);
      check("fill_waits", w, 0);
    end
    @(negedge Pclk);
    check("fill_wfull", {31'd0, wfull}, 32'd1);
    check("fill_tx_head", tx_data, 32'h1);
    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("status_full", rd, 32'h0000_0803);

    apb(1'b1, BASE, 32'hAA, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("wr_timeout_waits", w, 16);
    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("status_err_set", rd, 32'h8000_0803);
    apb(1'b1, BASE + 32'd8, 32'd1, 0, 1'b0, 1'b0, 32'd0, rd, w);
    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("status_err_clr", rd, 32'h0000_0803);

    apb(1'b1, BASE, 32'hAA, 3, 1'b1, 1'b0, 32'd0, rd, w);
    check("wr_pulse_waits", w, 3);
    tx_ready = 1'b1;
    repeat (7) @(posedge Pclk);
    @(negedge Pclk);
    check("tx_last_entry", tx_data, 32'hAA);
    @(posedge Pclk); #1;
    tx_ready = 1'b0;
    @(negedge Pclk);
    check("tx_drained", {31'd0, tx_valid}, 32'd0);
    @(posedge Pclk); #1;

    apb(1'b0, BASE, 32'd0, 3, 1'b0, 1'b1, 32'h55, rd, w);
    check("rd_wait_waits", w, 3);
    check("rd_wait_data", rd, 32'h55);
    @(negedge Pclk);
    check("rd_wait_rempty", {31'd0, rempty}, 32'd1);
    @(posedge Pclk); #1;

    apb(1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("rd_timeout_waits", w, 16);
    check("rd_timeout_data", rd, 32'hDEAD_BEEF);
    apb(1'b1, BASE + 32'd8, 32'd1, 0, 1'b0, 1'b0, 32'd0, rd, w);

    rx_valid = 1'b1; rx_data = 32'h11;
    @(posedge Pclk); #1 rx_data = 32'h22;
    @(posedge Pclk); #1 rx_valid = 1'b0;
    apb(1'b0, BASE, 32'd0, 1, 1'b0, 1'b1, 32'h33, rd, w);
    check("rx_simul_data", rd, 32'h11);
    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("rx_simul_status", rd, 32'h0002_0000);
    apb(1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("rx_second", rd, 32'h22);
    apb(1'b0, BASE, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("rx_third", rd, 32'h33);

    apb(1'b1, BASE + 32'd4, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 32'd0, rd, w);
    apb(1'b0, BASE + 32'd8, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("ctrl_read", rd, 32'd0);
    apb(1'b0, BASE + 32'd12, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("unmapped_read", rd, 32'd0);
    check("unmapped_waits", w, 0);

    apb(1'b1, BASE, 32'h77, 0, 1'b0, 1'b0, 32'd0, rd, w);
    Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b0; Paddr = BASE;
    @(posedge Pclk); #1 Penable = 1'b1;
    repeat (2) @(posedge Pclk);
    #1 Preset = 1'b1;
    @(negedge Pclk);
    check("reset_mid_pready", {31'd0, Pready}, 32'd0);
    check("reset_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
    @(posedge Pclk); #1;
    Psel = 1'b0; Penable = 1'b0;
    @(posedge Pclk); #1 Preset = 1'b0;
    apb(1'b0, BASE + 32'd12, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("post_reset_unmapped", rd, 32'd0);
    check("post_reset_waits", w, 0);
    apb(1'b0, BASE + 32'd4, 32'd0, 0, 1'b0, 1'b0, 32'd0, rd, w);
    check("post_reset_status", rd, 32'h0000_0002);

    repeat (2) @(posedge Pclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
